// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// The FSM state encoding and the operation-mode constants live here so every file agrees on them.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell, gate level.
// This is the only arithmetic element in the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic ab_x;
    logic ab_a;
    logic xc_a;

    assign ab_x  = a ^ b;
    assign ab_a  = a & b;
    assign xc_a  = ab_x & c;
    assign sum   = ab_x ^ c;
    assign carry = ab_a | xc_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full_adder, a carry flop, LSB-first operand shifting,
// and valid/ready handshakes on both the operand side and the result side.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    state_e           state_q;
    logic [WIDTH-1:0] shift_a_q;
    logic [WIDTH-1:0] shift_b_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             carry_msb_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] shift_a_d;
    logic [WIDTH-1:0] shift_b_d;
    logic [WIDTH-1:0] result_d;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (shift_a_q[0]),
        .b     (shift_b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Operands drain LSB first; sums enter from the MSB end so bit 0 lands last in place.
    assign shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
    assign shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
    assign result_d  = {fa_sum, result_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_a_q  <= op_a;
                        shift_b_q  <= (sub == MODE_SUB) ? ~op_b : op_b;
                        carry_q    <= (sub == MODE_SUB) ? 1'b1 : cin;
                        result_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    shift_a_q <= shift_a_d;
                    shift_b_q <= shift_b_d;
                    result_q  <= result_d;
                    carry_q   <= fa_carry;
                    if (cnt_q == CNT_PENULT) begin
                        carry_msb_q <= fa_carry;
                    end
                    // Counter holds at the last bit instead of wrapping.
                    if (cnt_q == CNT_LAST) begin
                        cout_q      <= fa_carry;
                        ovf_q       <= carry_msb_q ^ fa_carry;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for arithmetic, handshake and reset
// behaviour, plus a 2-bit instance for the narrowest legal width.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;

    logic       in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [7:0] op_a, op_b, result;

    logic       in_valid2, in_ready2, sub2, cin2, out_valid2, out_ready2, cout2, ovf2;
    logic [1:0] op_a2, op_b2, result2;

    int n_total;
    int n_pass;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .op_a      (op_a2),
        .op_b      (op_b2),
        .sub       (sub2),
        .cin       (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .result    (result2),
        .cout      (cout2),
        .ovf       (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic ci,
                          input logic [7:0] er, input logic ec, input logic eo);
        int lat;
        op_a = a; op_b = b; sub = s; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op2(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic s, input logic ci,
                           input logic [1:0] er, input logic ec, input logic eo);
        int lat;
        op_a2 = a; op_b2 = b; sub2 = s; cin2 = ci; in_valid2 = 1'b1; out_ready2 = 1'b0;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_result"}, 64'(result2), 64'(er));
        chk({tag, "_cout"}, 64'(cout2), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf2), 64'(eo));
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk({tag, "_idle_ready"}, 64'(in_ready2), 64'd1);
    endtask

    initial begin
        int lat;
        int cyc;
        int n_acc;
        int n_res;
        int acc_t[4];
        logic [7:0] res[4];
        logic rdy_pre;

        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; op_a2 = '0; op_b2 = '0; sub2 = 1'b0; cin2 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready_w2", 64'(in_ready2), 64'd1);

        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_5_3",   8'd5,  8'd3,  1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        run_op("sub_3_5",   8'd3,  8'd5,  1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure: hold the result in DONE while new operands wait on in_valid.
        op_a = 8'h12; op_b = 8'h34; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'd8);
        op_a = 8'h20; op_b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_result", 64'(result), 64'h46);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        chk("bp_hold_cout", 64'(cout), 64'd0);
        chk("bp_hold_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_after_hs_in_ready", 64'(in_ready), 64'd1);
        chk("bp_after_hs_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_accepted", 64'(in_ready), 64'd0);
        wait_out(lat);
        chk("bp2_latency", 64'(lat), 64'd8);
        chk("bp2_result", 64'(result), 64'h30);
        chk("bp2_cout", 64'(cout), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset with the counter at 3: three RUN edges after the accept edge.
        op_a = 8'h55; op_b = 8'h11; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        repeat (10) begin
            tick();
            chk("midrst_no_output", 64'(out_valid), 64'd0);
        end
        run_op("post_rst", 8'h0A, 8'h05, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready tied high.
        op_a = 8'd1; op_b = 8'd2; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; n_acc = 0; n_res = 0;
        while (n_res < 2 && cyc < 80) begin
            rdy_pre = in_ready;
            tick();
            cyc++;
            if (rdy_pre && in_valid && n_acc < 4) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                op_a = 8'd3; op_b = 8'd4;
            end
            if (out_valid && n_res < 4) begin
                res[n_res] = result;
                n_res++;
                if (n_res == 2) in_valid = 1'b0;
            end
        end
        chk("b2b_results_seen", 64'(n_res), 64'd2);
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        chk("b2b_res0", 64'(res[0]), 64'h03);
        chk("b2b_res1", 64'(res[1]), 64'h07);
        chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd10);
        tick();
        out_ready = 1'b0;

        run_op2("w2_add_1_1",  2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
        run_op2("w2_sub_0_1",  2'b00, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        run_op2("w2_add_2_2",  2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        run_op2("w2_add_3_3c", 2'b11, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller built around one instance of the team's gate-level full_adder cell.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Feeds the adder one bit pair per cycle, LSB first, and holds the carry in a flip-flop between cycles.
- Presents the WIDTH-bit result, carry-out and signed overflow over an output valid/ready handshake.
- Used wherever area matters more than latency (e.g. slow accumulators, configuration arithmetic).

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  controller can accept a new operation.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- sub  input  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced to 1, cin ignored).
- cin  input  1  carry-in for add mode.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  sum/difference.
- cout  output  1  final carry-out; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge), from any state:
  - state=IDLE; in_ready=1; out_valid=0; result=0; cout=0; ovf=0.
  - Bit counter, carry flop and operand shift registers cleared.
  - An operation in flight is discarded with no output.
- FSM states IDLE, RUN, DONE; encoding lives in the shared package.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge:
    - Load shift_a=op_a and shift_b = sub ? ~op_b : op_b.
    - Load carry = sub ? 1 : cin.
    - cnt=0; clear result shift register; go to RUN.
  - Operands are sampled only on this edge; later input changes are ignored.
- RUN:
  - in_ready=0, out_valid=0.
  - Adder inputs each cycle: a=shift_a[0], b=shift_b[0], c=carry.
  - Each edge:
    - Shift shift_a and shift_b right by 1.
    - Shift the adder sum into result from the MSB end (result = {sum, result[WIDTH-1:1]}).
    - carry <= adder carry; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-2: capture carry_msb_in <= adder carry (the carry into the MSB).
  - On the edge where cnt==WIDTH-1:
    - cout <= adder carry; ovf <= carry_msb_in ^ adder carry.
    - Go to DONE.
- DONE:
  - out_valid=1; result, cout and ovf held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE; out_valid drops the next cycle.
  - The result registers keep their last value in IDLE; they are meaningful only while out_valid=1.
- Latency: accept edge at cycle 0 → out_valid high after edge WIDTH (WIDTH RUN cycles).
  - Throughput: one operation per WIDTH+2 cycles with out_ready held 1 (accept, WIDTH RUN cycles, DONE handshake, IDLE).
- No operation overlap: in_ready=0 in RUN and DONE. in_valid asserted there is not consumed; the source holds it.
- Arithmetic is modulo 2^WIDTH. cout and ovf are always computed, regardless of mode.
- Counter never wraps: the exit is at cnt==WIDTH-1, and cnt is reset on load.
- Boundary: WIDTH=2 must work; the carry_msb_in capture then happens on the first RUN edge.

Decomposition:
- Shared package/header:
  - FSM state localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Operation-mode constant (MODE_ADD=1'b0, MODE_SUB=1'b1).
- One sub-module: the existing full_adder cell, instantiated once (ports a, b, c, sum, carry).
- Controller FSM, shift registers and counter are flat in serial_add_ctrl.

Test Plan:
- WIDTH=8, add 8'hFF+8'h01, cin=0:
  - out_valid first seen exactly 8 cycles after the accept edge.
  - result=8'h00, cout=1, ovf=0.
- Sub 8'd5−8'd3 → result=8'h02, cout=1, ovf=0. Sub 8'd3−8'd5 → result=8'hFE, cout=0, ovf=0.
- Add 8'h7F+8'h01, cin=0 → result=8'h80, cout=0, ovf=1. Add 8'h80+8'h80 → 8'h00, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → result/cout/ovf stable, in_ready=0.
  - in_valid held high with new operands is not accepted until one cycle after the out handshake.
- Reset mid-RUN: assert rst at cnt=3.
  - Next cycle in_ready=1, out_valid=0, result=0.
  - A following 8'h0A+8'h05, cin=1 yields 8'h10, cout=0.
- Back-to-back with in_valid and out_ready tied 1, operations 1+2 then 3+4 → results 8'h03 then 8'h07, accept edges spaced WIDTH+2 cycles apart.
